// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for a shared combinational ALU.
// Accepts one operation at a time, registers it onto the ALU inputs, captures
// the ALU result/flags one cycle later and returns them to the owning
// requester over a valid/ready response. Illegal opcodes skip the ALU cycle
// and answer immediately with an error and zeroed result/flags.
module alu_arbiter #(
  parameter int WIDTH  = 4,
  parameter int CODE_W = 4,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // request side
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [CODE_W-1:0] req_code0,
  input  logic [CODE_W-1:0] req_code1,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_b1,
  // ALU side
  output logic [CODE_W-1:0] alu_code,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  // response side
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [WIDTH-1:0]  resp_result,
  output logic [FLAG_W-1:0] resp_flags,
  output logic              resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // requester that owns the in-flight op
  logic                ptr_q,   ptr_d;     // preferred requester under contention
  logic [CODE_W-1:0]   code_q,  code_d;
  logic [WIDTH-1:0]    a_q,     a_d;
  logic [WIDTH-1:0]    b_q,     b_d;
  logic [WIDTH-1:0]    res_q,   res_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                err_q,   err_d;

  logic                any_req;
  logic                gnt_idx;
  logic [CODE_W-1:0]   sel_code;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic                accept;

  // Opcodes the ALU implements; anything else is answered with resp_err.
  function automatic logic is_legal(input logic [CODE_W-1:0] code);
    case (code)
      CODE_W'('h0), CODE_W'('h1),
      CODE_W'('h4), CODE_W'('h5),
      CODE_W'('h8), CODE_W'('h9), CODE_W'('hA): is_legal = 1'b1;
      default:                                   is_legal = 1'b0;
    endcase
  endfunction

  // Pick the requester to serve: a lone requester wins, otherwise the pointer.
  always_comb begin
    any_req  = |req_valid;
    gnt_idx  = (&req_valid) ? ptr_q : req_valid[1];
    sel_code = gnt_idx ? req_code1 : req_code0;
    sel_a    = gnt_idx ? req_a1    : req_a0;
    sel_b    = gnt_idx ? req_b1    : req_b0;
    // Reset also forces the ready strobe low while requesters may still be
    // holding valid, so the accept strobe never glitches during reset.
    accept   = (state_q == IDLE) && any_req && rst_n;
    req_ready = 2'b00;
    if (accept) req_ready = gnt_idx ? 2'b10 : 2'b01;
  end

  // Response valid is a pure function of state, so reset clears it at once.
  always_comb begin
    resp_valid = 2'b00;
    if (state_q == RESP) resp_valid = owner_q ? 2'b10 : 2'b01;
  end

  // Next-state and datapath-load logic for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    code_d  = code_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          code_d  = sel_code;
          a_d     = sel_a;
          b_d     = sel_b;
          owner_d = gnt_idx;
          if (is_legal(sel_code)) begin
            state_d = EXEC;
          end else begin
            res_d   = '0;
            flags_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        // ALU inputs have been stable for the whole cycle; take its answer.
        res_d   = alu_result;
        flags_d = alu_flags;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        // Only the owner's ready bit completes the response.
        if (resp_ready[owner_q]) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      code_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign alu_code    = code_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp_result = res_q;
  assign resp_flags  = flags_q;
  assign resp_err    = err_q;

endmodule
